// File: rtl/seg7_scan_mux.sv
// Purpose : 4-digit common-anode 7-segment scan driver with per-change anode blanking
//           and frame-boundary commit of a shadowed 16-bit display word.
// Latency : outputs registered; a sel change at cycle N blanks from N+1, new digit at N+BLANK_CYC+2.
// Backpressure: none; data_load is a strobe and later loads overwrite the shadow (last wins).
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   sel[1:0]        digit selector from the refresh counter (synchronous to clk)
//   data_in[15:0]   display word, [15:12] = digit 3 (leftmost), [3:0] = digit 0
//   dp_in[3:0]      decimal points, bit i = digit i, 1 = lit
//   data_load       strobe: capture data_in/dp_in into the shadow register
//   load_pend       shadow holds data not yet committed to the display
//   an[3:0]         anodes, active-low, an[i] = digit i
//   seg[6:0]        segments, active-low, {g,f,e,d,c,b,a}
//   dp              decimal point, active-low
//
// Build option: define SEG7_LZ_BLANK_EN to blank leading zeros on digits 3..1.

module seg7_scan_mux #(
    parameter int BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic [15:0] data_in,
    input  logic [3:0] dp_in,
    input  logic       data_load,
    output logic       load_pend,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      r_sel_q;
    logic [19:0]     r_shadow;   // {dp[3:0], data[15:0]}
    logic [19:0]     r_disp;
    logic            r_pend;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic            w_change;
    logic            w_wrap;
    logic [3:0]      w_nibble;
    logic [3:0]      w_dp_disp;
    logic            w_lz_blank;
    logic [3:0]      w_an_nxt;
    logic [6:0]      w_seg_nxt;
    logic            w_dp_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_change  = (sel != r_sel_q);
    // Only the 3->0 step is a frame boundary; glitchy jumps such as 1->3 never commit.
    assign w_wrap    = w_change && (r_sel_q == 2'd3) && (sel == 2'd0);
    assign w_nibble  = r_disp[{r_sel_q, 2'b00} +: 4];
    assign w_dp_disp = r_disp[19:16];

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_sel_q)
            2'd3:    w_lz_blank = (r_disp[15:12] == 4'h0);
            2'd2:    w_lz_blank = (r_disp[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (r_disp[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Next-state and next-output logic. Outputs are computed from the next
    // state so the registered an/seg/dp line up with the state register.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_an_nxt    = 4'hF;
        w_seg_nxt   = 7'h7F;
        w_dp_nxt    = 1'b1;

        case (r_state)
            ST_BLANK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_DRIVE;
            end
        endcase

        if (w_change) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = BLANK_LD;
        end

        // Entering or staying in DRIVE implies no change, so sel == r_sel_q and
        // the display cannot be committing this cycle.
        if (w_state_nxt == ST_DRIVE) begin
            w_an_nxt  = ~(4'b0001 << r_sel_q);
            w_seg_nxt = w_lz_blank ? 7'h7F : f_decode(w_nibble);
            w_dp_nxt  = ~w_dp_disp[r_sel_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= BLANK_LD;
            r_an    <= 4'hF;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
        end
    end

    // Shadow / display / pending flag. On a wrap coincident with a load the
    // display takes the old shadow and the pending flag stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_q  <= 2'd0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_sel_q <= sel;
            if (data_load) begin
                r_shadow <= {dp_in, data_in};
            end
            if (w_wrap) begin
                r_disp <= r_shadow;
            end
            if (data_load) begin
                r_pend <= 1'b1;
            end else if (w_wrap) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign load_pend = r_pend;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int B = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        data_load;
    logic        load_pend;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan_mux #(.BLANK_CYC(B)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .data_load (data_load),
        .load_pend (load_pend),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: state after the most recent clock edge.
    logic [1:0]  m_sel_q;
    logic [19:0] m_shadow;
    logic [19:0] m_disp;
    logic        m_pend;
    int          m_quiet;   // edges since the last observed sel change (or reset)

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        m_sel_q  = 2'd0;
        m_shadow = '0;
        m_disp   = '0;
        m_pend   = 1'b0;
        m_quiet  = 0;
    endtask

    task automatic check_outputs();
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        int          idx;
        idx   = int'(m_sel_q);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (m_quiet >= B + 1) begin
            e_an  = ~(4'b0001 << idx);
            e_seg = DEC[(m_disp[15:0] >> (4 * idx)) & 16'hF];
`ifdef SEG7_LZ_BLANK_EN
            if (idx > 0 && (m_disp[15:0] >> (4 * idx)) == 16'h0) e_seg = 7'h7F;
`endif
            e_dp  = ~m_disp[16 + idx];
        end
        chk("an",        16'(an),        16'(e_an));
        chk("seg",       16'(seg),       16'(e_seg));
        chk("dp",        16'(dp),        16'(e_dp));
        chk("load_pend", 16'(load_pend), 16'(m_pend));
    endtask

    // Drive one cycle's inputs (called at a negedge), advance the model over
    // the coming rising edge, then check at the following negedge.
    task automatic cyc(input logic [1:0] s, input logic ld, input logic [15:0] d, input logic [3:0] p);
        logic chg;
        logic wrap;
        sel       = s;
        data_load = ld;
        data_in   = d;
        dp_in     = p;
        chg  = (s != m_sel_q);
        wrap = chg && (m_sel_q == 2'd3) && (s == 2'd0);
        if (wrap) m_disp = m_shadow;
        if (ld) begin
            m_shadow = {p, d};
            m_pend   = 1'b1;
        end else if (wrap) begin
            m_pend = 1'b0;
        end
        m_quiet = chg ? 0 : ((m_quiet < 1000) ? m_quiet + 1 : m_quiet);
        m_sel_q = s;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(s, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        logic [1:0]  rs;
        int          hold_left;
        logic [15:0] rd;
        logic [15:0] mask;
        int          r;

        rst_n     = 1'b0;
        sel       = 2'd0;
        data_in   = 16'h0;
        dp_in     = 4'h0;
        data_load = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Power-up blank then digit 0 of an all-zero display; load arrives meanwhile.
        hold(2'd0, 4);
        cyc(2'd0, 1'b1, 16'h12AF, 4'h0);
        hold(2'd0, 8);
        hold(2'd1, 12);
        hold(2'd2, 12);
        hold(2'd3, 12);
        hold(2'd0, 12);   // wrap commits 12AF
        hold(2'd1, 12);
        hold(2'd2, 12);
        hold(2'd3, 12);

        // Restart of blanking by a second change four cycles in.
        hold(2'd0, 4);
        hold(2'd1, 12);

        // Two loads before a wrap (last wins), then a load on the wrap cycle.
        cyc(2'd1, 1'b1, 16'h1111, 4'h5);
        hold(2'd2, 3);
        cyc(2'd2, 1'b1, 16'h2222, 4'hA);
        hold(2'd3, 12);
        hold(2'd0, 12);
        hold(2'd3, 12);
        cyc(2'd0, 1'b1, 16'h0050, 4'h2);
        hold(2'd0, 11);
        hold(2'd1, 12);
        hold(2'd2, 12);
        hold(2'd3, 12);
        hold(2'd0, 12);
        hold(2'd1, 12);
        hold(2'd2, 12);
        hold(2'd3, 12);

        // Non-wrap jump 1->3 must not commit.
        cyc(2'd3, 1'b1, 16'hBEEF, 4'hF);
        hold(2'd1, 12);
        hold(2'd3, 12);

        // Asynchronous reset while a digit is driven and a load is pending.
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_an",   16'(an),        16'hF);
        chk("rst_seg",  16'(seg),       16'h7F);
        chk("rst_dp",   16'(dp),        16'h1);
        chk("rst_pend", 16'(load_pend), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(2'd3, 12);
        hold(2'd0, 12);

        // Randomized phase.
        rs        = 2'd0;
        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_left == 0) begin
                r = $urandom_range(0, 99);
                if (r < 65)      rs = rs + 2'd1;
                else if (r < 85) rs = 2'($urandom_range(0, 3));
                hold_left = (r % 7 == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
            end
            hold_left--;
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            rd = 16'($urandom) & mask;
            cyc(rs, ($urandom_range(0, 7) == 0), rd, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
